// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution scheduler: window markers and FSM states.
package conv_pkg;

    typedef struct packed {
        logic sop;
        logic eop;
        logic sof;
        logic eof;
    } marker_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Start markers travel with the first kernel of a window, end markers with the last.
    function automatic marker_t issue_markers(marker_t mk, logic first, logic last);
        marker_t m;
        m.sop = mk.sop & first;
        m.eop = mk.eop & last;
        m.sof = mk.sof & first;
        m.eof = mk.eof & last;
        return m;
    endfunction

endpackage

// File: rtl/delay_rg.sv
// Fixed-depth register delay line with asynchronous clear.
module delay_rg #(
    parameter int W = 5,
    parameter int D = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] r_pipe [D];

    // Shift stage-by-stage every cycle, free-running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < D; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[D-1];

endmodule

// File: rtl/conv3x3_kernel_sched.sv
// Holds one pixel window while stepping the kernel ROM address through every kernel,
// tags issues with frame/line markers and realigns them to the conv pipeline output.
module conv3x3_kernel_sched
    import conv_pkg::*;
#(
    parameter int KERNEL_NUM = 16,
    parameter int ADDR_WIDTH = $clog2(KERNEL_NUM),
    parameter int PIPE_LAT   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  stall_i,
    input  logic                  win_valid_i,
    output logic                  win_ready_o,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic                  sof_i,
    input  logic                  eof_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  issue_o,
    output logic                  first_k_o,
    output logic                  last_k_o,
    output logic                  res_valid_o,
    output logic                  res_sop_o,
    output logic                  res_eop_o,
    output logic                  res_sof_o,
    output logic                  res_eof_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(KERNEL_NUM - 1);
    localparam int                    DCNT_W = $clog2(PIPE_LAT + 1);
    localparam logic [DCNT_W-1:0]     D_LAST = DCNT_W'(PIPE_LAT);

    sched_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_k;
    marker_t               r_mk;
    logic [DCNT_W-1:0]     r_dcnt;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_issue;
    logic                  r_first_k;
    logic                  r_last_k;
    marker_t               r_tag;
    logic                  r_frame_done;

    logic                  w_first;
    logic                  w_last;
    logic                  w_ready;
    logic                  w_accept;
    marker_t               w_win_mk;
    logic [4:0]            w_res;

    assign w_first  = (r_k == '0);
    assign w_last   = (r_k == K_LAST);
    assign w_ready  = enable_i && !stall_i && ((r_state == IDLE) || ((r_state == RUN) && w_last));
    assign w_accept = win_valid_i && w_ready;
    assign w_win_mk = '{sop: sop_i, eop: eop_i, sof: sof_i, eof: eof_i};

    // Scheduler FSM with kernel/drain counters and registered issue outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_mk         <= '0;
            r_dcnt       <= '0;
            r_rom_addr   <= '0;
            r_issue      <= 1'b0;
            r_first_k    <= 1'b0;
            r_last_k     <= 1'b0;
            r_tag        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_issue      <= 1'b0;
            r_first_k    <= 1'b0;
            r_last_k     <= 1'b0;
            r_tag        <= '0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mk    <= w_win_mk;
                        r_k     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Address follows k even while stalled so the held kernel stays visible
                    r_rom_addr <= r_k;
                    if (!stall_i) begin
                        r_issue   <= 1'b1;
                        r_first_k <= w_first;
                        r_last_k  <= w_last;
                        r_tag     <= issue_markers(r_mk, w_first, w_last);
                        if (w_last) begin
                            if (w_accept) begin
                                r_mk <= w_win_mk;
                                r_k  <= '0;
                            end else if (r_mk.eof) begin
                                r_dcnt  <= '0;
                                r_state <= DRAIN;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_k <= r_k + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (r_dcnt == D_LAST) begin
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_dcnt <= r_dcnt + DCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    delay_rg #(
        .W (5),
        .D (PIPE_LAT)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   ({r_issue, r_tag}),
        .dout  (w_res)
    );

    assign win_ready_o  = w_ready;
    assign rom_addr_o   = r_rom_addr;
    assign issue_o      = r_issue;
    assign first_k_o    = r_first_k;
    assign last_k_o     = r_last_k;
    assign res_valid_o  = w_res[4];
    assign res_sop_o    = w_res[3];
    assign res_eop_o    = w_res[2];
    assign res_sof_o    = w_res[1];
    assign res_eof_o    = w_res[0];
    assign busy_o       = (r_state != IDLE);
    assign frame_done_o = r_frame_done;

endmodule
